itcm_icb_ctrl: RTL and testbench

//   ICB responder for the ITCM: it is the ITCM end of the instruction-fetch ICB link.

---
 rtl/itcm_icb_ctrl_pkg.sv | 18 +
 rtl/itcm_sram.sv | 38 +++
 rtl/itcm_icb_ctrl.sv | 127 ++++++++++++
 tb/tb_itcm_icb_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/itcm_icb_ctrl_pkg.sv
// Shared widths and FSM encodings for the ITCM ICB responder.
// Optional write support is selected with the ITCM_ICB_WRITE_EN macro.
package itcm_icb_ctrl_pkg;

  // Default byte-address and data widths of the ITCM link
  localparam int unsigned ITCM_ADDR_WIDTH = 16;
  localparam int unsigned ITCM_DATA_WIDTH = 32;

  // Responder FSM encodings: IDLE = nothing pending, BUSY = response pending
  localparam logic [0:0] ITCM_ST_IDLE = 1'b0;
  localparam logic [0:0] ITCM_ST_BUSY = 1'b1;

  // Word index width for a given byte address width
  function automatic int unsigned itcm_idx_width(input int unsigned aw);
    return aw - 2;
  endfunction

endpackage

// File: rtl/itcm_sram.sv
// Behavioural single-port 1RW synchronous SRAM with byte write enables.
// Read-first: dout captures the addressed word on every enabled cycle.
module itcm_sram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IW    = 10
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] wmask_i,
  input  logic [IW-1:0]   index_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   dout_o
);

  localparam int unsigned MW = DW / 8;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_q;

  // Array write and registered read port; dout holds while en is low
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      dout_q <= mem_q[index_i];
      if (we_i) begin
        for (int b = 0; b < MW; b++) begin
          if (wmask_i[b]) begin
            mem_q[index_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/itcm_icb_ctrl.sv
// ITCM end of the instruction-fetch ICB link: one-word requests, one
// response exactly one cycle after accept, at most one outstanding.
// Define ITCM_ICB_WRITE_EN to add the write channel (read/wdata/wmask).
module itcm_icb_ctrl
  import itcm_icb_ctrl_pkg::*;
#(
  parameter int unsigned AW    = ITCM_ADDR_WIDTH,
  parameter int unsigned DW    = ITCM_DATA_WIDTH,
  parameter int unsigned DEPTH = 2 ** (AW - 2)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            itcm_icb_req_valid_i,
  output logic            itcm_icb_req_ready_o,
  input  logic [AW-1:0]   itcm_icb_req_addr_i,
`ifdef ITCM_ICB_WRITE_EN
  input  logic            itcm_icb_req_read_i,
  input  logic [DW-1:0]   itcm_icb_req_wdata_i,
  input  logic [DW/8-1:0] itcm_icb_req_wmask_i,
`endif
  output logic            itcm_icb_resp_valid_o,
  input  logic            itcm_icb_resp_ready_i,
  output logic            itcm_icb_resp_err_o,
  output logic [DW-1:0]   itcm_icb_resp_rdata_o
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned XW = itcm_idx_width(AW);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:0]    state_q, state_d;
  logic          err_q, err_d;
  logic          rd_q, rd_d;

  logic          resp_valid_c;
  logic          accept_c;
  logic          retire_c;
  logic [XW-1:0] req_idx_c;
  logic          misalign_c;
  logic          oor_c;
  logic          req_err_c;
  logic          req_read_c;
  logic [DW-1:0] req_wdata_c;
  logic [MW-1:0] req_wmask_c;
  logic          sram_en_c;
  logic          sram_we_c;
  logic [DW-1:0] sram_dout_c;

  // Request payload; without the write channel every request is a read
`ifdef ITCM_ICB_WRITE_EN
  assign req_read_c  = itcm_icb_req_read_i;
  assign req_wdata_c = itcm_icb_req_wdata_i;
  assign req_wmask_c = itcm_icb_req_wmask_i;
`else
  assign req_read_c  = 1'b1;
  assign req_wdata_c = '0;
  assign req_wmask_c = '0;
`endif

  // Handshakes: ready depends only on state and resp_ready, never on req_valid
  assign resp_valid_c         = (state_q == ITCM_ST_BUSY);
  assign itcm_icb_req_ready_o = (state_q == ITCM_ST_IDLE) | itcm_icb_resp_ready_i;
  assign accept_c             = itcm_icb_req_valid_i & itcm_icb_req_ready_o;
  assign retire_c             = resp_valid_c & itcm_icb_resp_ready_i;

  // Misaligned or beyond the physical array: flagged at accept, no SRAM access
  assign req_idx_c  = itcm_icb_req_addr_i[AW-1:2];
  assign misalign_c = |itcm_icb_req_addr_i[1:0];
  assign oor_c      = ({1'b0, req_idx_c} >= (XW + 1)'(DEPTH));
  assign req_err_c  = misalign_c | oor_c;

  // SRAM strobes only on a clean accept; a stalled response keeps dout frozen
  assign sram_en_c = accept_c & ~req_err_c & (req_read_c | (|req_wmask_c));
`ifdef ITCM_ICB_WRITE_EN
  assign sram_we_c = sram_en_c & ~req_read_c;
`else
  assign sram_we_c = 1'b0;
`endif

  // Next-state: accept wins (it may coincide with a retire), else retire to IDLE
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rd_d    = rd_q;
    if (accept_c) begin
      state_d = ITCM_ST_BUSY;
      err_d   = req_err_c;
      rd_d    = req_read_c;
    end else if (retire_c) begin
      state_d = ITCM_ST_IDLE;
      err_d   = 1'b0;
    end
  end

  // State and response attribute registers; reset drops any pending response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ITCM_ST_IDLE;
      err_q   <= 1'b0;
      rd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  itcm_sram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (sram_en_c),
    .we_i    (sram_we_c),
    .wmask_i (req_wmask_c),
    .index_i (IW'(req_idx_c)),
    .wdata_i (req_wdata_c),
    .dout_o  (sram_dout_c)
  );

  // Response outputs; data only for a valid, error-free read
  assign itcm_icb_resp_valid_o = resp_valid_c;
  assign itcm_icb_resp_err_o   = err_q;
  assign itcm_icb_resp_rdata_o = (resp_valid_c & ~err_q & rd_q) ? sram_dout_c : '0;

endmodule

// File: tb/tb_itcm_icb_ctrl.sv
// Self-checking bench for itcm_icb_ctrl: directed cases plus random traffic
// checked against a transaction-level model of the ITCM.
module tb_itcm_icb_ctrl;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_read = 1'b1;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wmask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_err;
  logic [DW-1:0] resp_rdata;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic        exp_pend  = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_rdata = '0;

  always #5 clk_i = ~clk_i;

  itcm_icb_ctrl #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .itcm_icb_req_valid_i  (req_valid),
    .itcm_icb_req_ready_o  (req_ready),
    .itcm_icb_req_addr_i   (req_addr),
`ifdef ITCM_ICB_WRITE_EN
    .itcm_icb_req_read_i   (req_read),
    .itcm_icb_req_wdata_i  (req_wdata),
    .itcm_icb_req_wmask_i  (req_wmask),
`endif
    .itcm_icb_resp_valid_o (resp_valid),
    .itcm_icb_resp_ready_i (resp_ready),
    .itcm_icb_resp_err_o   (resp_err),
    .itcm_icb_resp_rdata_o (resp_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive in the low phase, check, then advance the model at the edge
  task automatic do_cycle(input logic v, input logic [AW-1:0] a, input logic rr,
                          input logic rd, input logic [31:0] wd, input logic [3:0] wm,
                          input logic stall_chk);
    logic        acc, bad, is_wr, en_exp;
    int unsigned idx;
    @(negedge clk_i);
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
    req_read   = rd;
    req_wdata  = wd;
    req_wmask  = wm;
    #1;
    check_eq("req_ready", 32'(req_ready), 32'(!exp_pend || rr));
    check_eq("resp_valid", 32'(resp_valid), 32'(exp_pend));
    if (exp_pend) begin
      check_eq("resp_err", 32'(resp_err), 32'(exp_err));
      check_eq("resp_rdata", resp_rdata, exp_rdata);
    end else begin
      check_eq("idle_rdata", resp_rdata, 32'h0);
    end
`ifdef ITCM_ICB_WRITE_EN
    is_wr = !rd;
`else
    is_wr = 1'b0;
`endif
    acc = v && (!exp_pend || rr);
    idx = 32'(a) / 4;
    bad = (a % 4 != 0) || (idx >= DEPTH);
    en_exp = acc && !bad && (!is_wr || wm != 4'h0);
    if (stall_chk) check_eq("stall_sram_en", 32'(dut.sram_en_c), 32'(en_exp));
    if (acc) begin
      exp_pend  = 1'b1;
      exp_err   = bad;
      exp_rdata = (bad || is_wr) ? 32'h0 : ref_mem[idx];
      if (is_wr && !bad) begin
        for (int b = 0; b < 4; b++) begin
          if (wm[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
    end else if (exp_pend && rr) begin
      exp_pend = 1'b0;
    end
  endtask

  task automatic rd_cycle(input logic v, input logic [AW-1:0] a, input logic rr);
    do_cycle(v, a, rr, 1'b1, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'hDEADBEEF;
    for (int i = 0; i < DEPTH; i++) dut.u_sram.mem_q[i] = ref_mem[i];

    // Reset values
    resp_ready = 1'b0;
    #2;
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_err", 32'(resp_err), 32'h0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single read of the preloaded word
    rd_cycle(1'b1, 16'h0014, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);

    // Back-to-back reads with resp_ready held high
    rd_cycle(1'b1, 16'h0000, 1'b1);
    rd_cycle(1'b1, 16'h0004, 1'b1);
    rd_cycle(1'b1, 16'h0008, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);

    // Stall: response held four cycles while new requests are offered
    rd_cycle(1'b1, 16'h000C, 1'b1);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 16'h0010, 1'b0, 1'b1, 32'h0, 4'h0, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);

    // Errors: misaligned and beyond DEPTH
    rd_cycle(1'b1, 16'h0006, 1'b1);
    rd_cycle(1'b1, 16'h1000, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);

    // Reset while a stalled response is pending
    rd_cycle(1'b1, 16'h0014, 1'b0);
    rd_cycle(1'b0, 16'h0000, 1'b0);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("rst_busy_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_busy_rdata", resp_rdata, 32'h0);
    exp_pend = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_eq("rst_rel_ready", 32'(req_ready), 32'h1);
    rd_cycle(1'b0, 16'h0000, 1'b0);
    rd_cycle(1'b0, 16'h0000, 1'b1);

`ifdef ITCM_ICB_WRITE_EN
    // Partial write then read back
    do_cycle(1'b1, 16'h0020, 1'b1, 1'b0, 32'h12345678, 4'b0011, 1'b0);
    rd_cycle(1'b1, 16'h0020, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = AW'(($urandom_range(0, 16383) * 4) + $urandom_range(1, 3));
        1:       ra = AW'($urandom_range(DEPTH, 16383) * 4);
        default: ra = AW'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      do_cycle($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0,
`ifdef ITCM_ICB_WRITE_EN
               $urandom_range(0, 2) != 0, $urandom, 4'($urandom),
`else
               1'b1, 32'h0, 4'h0,
`endif
               1'b1);
    end
    rd_cycle(1'b0, 16'h0000, 1'b1);
    rd_cycle(1'b0, 16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
